// File: rtl/touch_adc_sequencer.sv
// Touch-panel ADC sequencer: pen-down debounce, X/Y SPI conversion frames, scaled coordinate publish.
// Optional build macro TOUCH_AVG_EN: publish the mean of four consecutive X/Y pairs.

module touch_adc_sequencer #(
    parameter int unsigned CLK_DIV  = 16,
    parameter int unsigned DEBOUNCE = 1024,
    parameter int unsigned GAP      = 4096
) (
    input  logic       sys_clk,
    input  logic       iRST_n,
    input  logic       penirq_n,
    input  logic       adc_dout,
    output logic       adc_dclk,
    output logic       adc_din,
    output logic       adc_cs_n,
    output logic [7:0] x_coord,
    output logic [9:0] y_coord,
    output logic       new_coord,
    output logic       transmit_en
);
    localparam int unsigned DIV_W   = $clog2(CLK_DIV);
    localparam int unsigned CNT_MAX = (DEBOUNCE > GAP) ? DEBOUNCE : GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned HP_W    = 6;
    localparam int unsigned HP_LAST = 49;
    localparam int unsigned RAW_W   = 12;
`ifdef TOUCH_AVG_EN
    localparam int unsigned XH_W    = 12;
    localparam int unsigned ACC_W   = 14;
`else
    localparam int unsigned XH_W    = 8;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_FRAME_X,
        S_FRAME_Y,
        S_UPDATE,
        S_GAP
    } state_t;

    state_t              state_q;
    logic [1:0]          pen_sync_q;
    logic [DIV_W-1:0]    div_q;
    logic [HP_W-1:0]     hp_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                cs_n_q;
    logic                dclk_q;
    logic                din_q;
    logic [RAW_W-1:0]    raw_q;
    logic [XH_W-1:0]     x_hold_q;
    logic [7:0]          x_q;
    logic [9:0]          y_q;
    logic                new_q;
    logic                ten_q;
`ifdef TOUCH_AVG_EN
    logic [ACC_W-1:0]    acc_x_q;
    logic [ACC_W-1:0]    acc_y_q;
    logic [1:0]          pairs_q;
    logic [ACC_W-1:0]    sum_x_c;
    logic [ACC_W-1:0]    sum_y_c;
`endif

    logic                pen_q;
    logic [7:0]          cmd_c;
    logic [4:0]          fall_n_c;
    logic                din_next_c;
    logic                sample_c;
    logic                tick_c;
    logic [CNT_W-1:0]    cnt_inc_c;

    assign pen_q       = pen_sync_q[1];
    assign adc_dclk    = dclk_q;
    assign adc_din     = din_q;
    assign adc_cs_n    = cs_n_q;
    assign x_coord     = x_q;
    assign y_coord     = y_q;
    assign new_coord   = new_q;
    assign transmit_en = ten_q;

    // Frame decode: half-period 0 is a cs_n-high guard, 1 is setup, odd halves 1..47 end with a rise.
    always_comb begin
        cmd_c      = 8'h90;
        din_next_c = 1'b0;
        if (state_q == S_FRAME_Y) begin
            cmd_c = 8'hD0;
        end
        fall_n_c = hp_q[5:1];
        if (fall_n_c < 5'd8) begin
            din_next_c = cmd_c[3'd7 - fall_n_c[2:0]];
        end
        sample_c  = hp_q[0] && (hp_q >= 6'd19) && (hp_q <= 6'd41);
        tick_c    = (div_q == DIV_W'(CLK_DIV - 1));
        cnt_inc_c = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
`ifdef TOUCH_AVG_EN
        sum_x_c   = acc_x_q + ACC_W'(x_hold_q);
        sum_y_c   = acc_y_q + ACC_W'(raw_q);
`endif
    end

    always_ff @(posedge sys_clk or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q    <= S_IDLE;
            pen_sync_q <= 2'b11;
            div_q      <= '0;
            hp_q       <= '0;
            cnt_q      <= '0;
            cs_n_q     <= 1'b1;
            dclk_q     <= 1'b0;
            din_q      <= 1'b0;
            raw_q      <= '0;
            x_hold_q   <= '0;
            x_q        <= '0;
            y_q        <= '0;
            new_q      <= 1'b0;
            ten_q      <= 1'b0;
`ifdef TOUCH_AVG_EN
            acc_x_q    <= '0;
            acc_y_q    <= '0;
            pairs_q    <= '0;
`endif
        end else begin
            pen_sync_q <= {pen_sync_q[0], penirq_n};
            new_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!pen_q) begin
                        state_q <= S_DEBOUNCE;
                        cnt_q   <= '0;
`ifdef TOUCH_AVG_EN
                        acc_x_q <= '0;
                        acc_y_q <= '0;
                        pairs_q <= '0;
`endif
                    end
                end
                S_DEBOUNCE: begin
                    if (pen_q) begin
                        state_q <= S_IDLE;
                    end else if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
                        state_q <= S_FRAME_X;
                        ten_q   <= 1'b1;
                        div_q   <= '0;
                        hp_q    <= '0;
                    end else begin
                        cnt_q <= cnt_inc_c;
                    end
                end
                S_FRAME_X, S_FRAME_Y: begin
                    if (!tick_c) begin
                        div_q <= div_q + DIV_W'(1);
                    end else begin
                        div_q <= '0;
                        hp_q  <= hp_q + HP_W'(1);
                        if (hp_q == '0) begin
                            cs_n_q <= 1'b0;
                            din_q  <= cmd_c[7];
                        end else if (hp_q == HP_W'(HP_LAST)) begin
                            cs_n_q <= 1'b1;
                            din_q  <= 1'b0;
                            hp_q   <= '0;
                            if (state_q == S_FRAME_X) begin
                                x_hold_q <= raw_q[RAW_W-1 -: XH_W];
                                state_q  <= S_FRAME_Y;
                            end else begin
                                state_q  <= S_UPDATE;
                            end
                        end else if (hp_q[0]) begin
                            dclk_q <= 1'b1;
                            if (sample_c) begin
                                raw_q <= {raw_q[RAW_W-2:0], adc_dout};
                            end
                        end else begin
                            dclk_q <= 1'b0;
                            din_q  <= din_next_c;
                        end
                    end
                end
                S_UPDATE: begin
                    state_q <= S_GAP;
                    cnt_q   <= '0;
`ifdef TOUCH_AVG_EN
                    if (pairs_q == 2'd3) begin
                        x_q     <= sum_x_c[13:6];
                        y_q     <= sum_y_c[13:4];
                        new_q   <= 1'b1;
                        acc_x_q <= '0;
                        acc_y_q <= '0;
                        pairs_q <= '0;
                    end else begin
                        acc_x_q <= sum_x_c;
                        acc_y_q <= sum_y_c;
                        pairs_q <= pairs_q + 2'd1;
                    end
`else
                    x_q   <= x_hold_q;
                    y_q   <= raw_q[11:2];
                    new_q <= 1'b1;
`endif
                end
                S_GAP: begin
                    // Pen state is only consulted here, so a release never truncates a frame.
                    if (cnt_q == CNT_W'(GAP - 1)) begin
                        if (pen_q) begin
                            state_q <= S_IDLE;
                            ten_q   <= 1'b0;
                        end else begin
                            state_q <= S_FRAME_X;
                            div_q   <= '0;
                            hp_q    <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_inc_c;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_touch_adc_sequencer.sv
// Scoreboard bench for touch_adc_sequencer: ADC serial model, frame monitor and coordinate scoreboard.

module tb_touch_adc_sequencer;
    localparam int unsigned CLK_DIV  = 2;
    localparam int unsigned DEBOUNCE = 1024;
    localparam int unsigned GAP      = 64;

    typedef struct packed {
        logic [7:0] x;
        logic [9:0] y;
    } coord_t;

    logic       sys_clk  = 1'b0;
    logic       iRST_n   = 1'b0;
    logic       penirq_n = 1'b1;
    logic       adc_dout = 1'b0;
    logic       adc_dclk;
    logic       adc_din;
    logic       adc_cs_n;
    logic [7:0] x_coord;
    logic [9:0] y_coord;
    logic       new_coord;
    logic       transmit_en;

    coord_t      exp_q[$];
    coord_t      e;
    int          checks = 0;
    int          failures = 0;
    logic [11:0] x_tbl [4];
    logic [11:0] y_tbl [4];
    int          ncyc = 0;
    int          rc = 0;
    int          p = 0;
    int          frames_started = 0;
    int          sess_frames = 0;
    int          last_rise = 0;
    int          din_viol = 0;
    logic [7:0]  cap_cmd = 8'h00;
    logic [11:0] val = 12'h000;
    bit          exp_y = 1'b0;
    bit          in_frame = 1'b0;
    logic        prev_cs = 1'b1;
    logic        prev_dclk = 1'b0;
    logic        prev_din = 1'b0;
    logic        prev_ten = 1'b0;

    always #5 sys_clk = ~sys_clk;

    touch_adc_sequencer #(
        .CLK_DIV (CLK_DIV),
        .DEBOUNCE(DEBOUNCE),
        .GAP     (GAP)
    ) dut (
        .sys_clk    (sys_clk),
        .iRST_n     (iRST_n),
        .penirq_n   (penirq_n),
        .adc_dout   (adc_dout),
        .adc_dclk   (adc_dclk),
        .adc_din    (adc_din),
        .adc_cs_n   (adc_cs_n),
        .x_coord    (x_coord),
        .y_coord    (y_coord),
        .new_coord  (new_coord),
        .transmit_en(transmit_en)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ADC model, frame monitor and coordinate scoreboard, all sampled on the falling sys_clk edge.
    always @(negedge sys_clk) begin
        ncyc++;
        if (!iRST_n) begin
            exp_y    = 1'b0;
            in_frame = 1'b0;
        end else begin
            if (transmit_en && !prev_ten) sess_frames = 0;
            if (!adc_cs_n && prev_cs) begin
                rc = 0;
                in_frame = 1'b1;
                frames_started++;
                sess_frames++;
            end
            if (adc_dclk && !prev_dclk) begin
                rc++;
                if (rc <= 8) cap_cmd = {cap_cmd[6:0], adc_din};
                if (adc_din !== prev_din) din_viol++;
            end else if (adc_dclk && prev_dclk && (adc_din !== prev_din)) begin
                din_viol++;
            end
            if (!adc_dclk && prev_dclk) begin
                if (rc == 9) begin
                    p = ((sess_frames - 1) / 2) % 4;
                    if (cap_cmd == 8'h90)      val = x_tbl[p];
                    else if (cap_cmd == 8'hD0) val = y_tbl[p];
                    else                       val = 12'h000;
                end
                if (rc >= 9 && rc <= 20) adc_dout = val[20 - rc];
                else                     adc_dout = 1'b0;
            end
            if (adc_cs_n && !prev_cs) begin
                last_rise = ncyc;
                if (in_frame) begin
                    check("frame_rises", rc, 24);
                    check("frame_cmd", int'(cap_cmd), exp_y ? 32'hD0 : 32'h90);
                    exp_y    = !exp_y;
                    in_frame = 1'b0;
                end
            end
            if (new_coord) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_strobe x=%0h y=%0h required=no strobe", x_coord, y_coord);
                end else begin
                    e = exp_q.pop_front();
                    check("x_coord", int'(x_coord), int'(e.x));
                    check("y_coord", int'(y_coord), int'(e.y));
                    check("strobe_latency", ncyc - last_rise, 1);
                end
            end
            if (!transmit_en && prev_ten) check("gap_to_idle", ncyc - last_rise, int'(GAP) + 1);
        end
        prev_cs   = adc_cs_n;
        prev_dclk = adc_dclk;
        prev_din  = adc_din;
        prev_ten  = transmit_en;
    end

    task automatic wait_frames(input int target);
        int b = 0;
        while (frames_started < target && b < 4000) begin
            @(negedge sys_clk);
            b++;
        end
        check("wait_frames", int'(frames_started >= target), 1);
    endtask

    task automatic wait_ten_low();
        int b = 0;
        while (transmit_en && b < 2000) begin
            @(negedge sys_clk);
            b++;
        end
        check("wait_transmit_low", int'(transmit_en), 0);
    endtask

    // Hold the pen for the given number of pairs, release 20 cycles into the last Y frame.
    task automatic run_session(input int pairs);
        int base;
        base = frames_started;
        penirq_n = 1'b0;
        wait_frames(base + 2 * pairs);
        repeat (20) @(negedge sys_clk);
        penirq_n = 1'b1;
        wait_ten_low();
        repeat (10) @(negedge sys_clk);
    endtask

    initial begin
        int viol;
        int b;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check("rst_cs_n", int'(adc_cs_n), 1);
        check("rst_dclk", int'(adc_dclk), 0);
        check("rst_din", int'(adc_din), 0);
        check("rst_x", int'(x_coord), 0);
        check("rst_y", int'(y_coord), 0);
        check("rst_new", int'(new_coord), 0);
        check("rst_ten", int'(transmit_en), 0);
        iRST_n = 1'b1;

        // Short pen blip below the debounce window.
        penirq_n = 1'b0;
        viol = 0;
        for (int i = 0; i < 1700; i++) begin
            if (i == 500) penirq_n = 1'b1;
            @(negedge sys_clk);
            if (transmit_en || !adc_cs_n) viol++;
        end
        check("blip_no_activity", viol, 0);
        check("blip_no_frames", frames_started, 0);

        // Single pair, pen released mid-Y frame.
        x_tbl[0] = 12'hA5C;
        y_tbl[0] = 12'h3F8;
`ifndef TOUCH_AVG_EN
        exp_q.push_back('{x: 8'hA5, y: 10'h0FE});
`endif
        run_session(1);

        // Four pairs.
        x_tbl[0] = 12'h100; x_tbl[1] = 12'h104; x_tbl[2] = 12'h108; x_tbl[3] = 12'h10C;
        y_tbl[0] = 12'h3F8; y_tbl[1] = 12'h004; y_tbl[2] = 12'hFFF; y_tbl[3] = 12'h801;
`ifdef TOUCH_AVG_EN
        exp_q.push_back('{x: 8'h10, y: 10'h1BF});
`else
        exp_q.push_back('{x: 8'h10, y: 10'h0FE});
        exp_q.push_back('{x: 8'h10, y: 10'h001});
        exp_q.push_back('{x: 8'h10, y: 10'h3FF});
        exp_q.push_back('{x: 8'h10, y: 10'h200});
`endif
        run_session(4);

        // Three pairs: a partial average is discarded.
`ifndef TOUCH_AVG_EN
        exp_q.push_back('{x: 8'h10, y: 10'h0FE});
        exp_q.push_back('{x: 8'h10, y: 10'h001});
        exp_q.push_back('{x: 8'h10, y: 10'h3FF});
`endif
        run_session(3);
        check("scoreboard_drained", exp_q.size(), 0);

        // Reset in the middle of an X frame at DCLK rise 12.
        b = frames_started;
        penirq_n = 1'b0;
        wait_frames(b + 1);
        b = 0;
        while (rc < 12 && b < 200) begin
            @(negedge sys_clk);
            b++;
        end
        check("reached_rise12", rc, 12);
        iRST_n   = 1'b0;
        penirq_n = 1'b1;
        #1;
        check("midframe_rst_cs_n", int'(adc_cs_n), 1);
        check("midframe_rst_dclk", int'(adc_dclk), 0);
        check("midframe_rst_ten", int'(transmit_en), 0);
        check("midframe_rst_x", int'(x_coord), 0);
        repeat (3) @(negedge sys_clk);
        iRST_n = 1'b1;
        viol = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge sys_clk);
            if (transmit_en || !adc_cs_n || adc_dclk) viol++;
        end
        check("post_rst_idle", viol, 0);
        check("din_stable_at_rise", din_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog actual=timeout required=completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
